// File: rtl/fine_interp_ch.sv
// Per-channel fine-delay interpolator: depth-indexed phase LUT selects one of
// eight 4-tap coefficient sets applied to the coarse-delayed sample stream.
module fine_interp_ch #(
    parameter int unsigned INPUT_WD  = 14,
    parameter int unsigned COEF_WD   = 16,
    parameter int unsigned FD_OUT_WD = 32,
    parameter int unsigned ADDR_WD   = 12,
    parameter int unsigned PH_WD     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_en,
    input  logic                    start,
    input  logic [ADDR_WD-1:0]      lut_addr,
    input  logic                    lut_we,
    input  logic [PH_WD-1:0]        lut_din,
    input  logic [PH_WD+1:0]        coef_addr,
    input  logic                    coef_we,
    input  logic [COEF_WD-1:0]      coef_din,
    input  logic [INPUT_WD-1:0]     fine_din,
    input  logic                    fine_din_valid,
    output logic [FD_OUT_WD-1:0]    fine_dout,
    output logic                    fine_dout_valid,
    output logic                    line_done
);

    localparam int unsigned NTAP      = 4;
    localparam int unsigned PROD_WD   = INPUT_WD + COEF_WD;
    localparam int unsigned NCOEF     = 2 ** (PH_WD + 2);
    localparam int unsigned LUT_DEPTH = 2 ** ADDR_WD;
    localparam int unsigned CNT_WD    = ADDR_WD + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e                       state_q, state_d;
    logic [CNT_WD-1:0]            cnt_q, cnt_d;
    logic signed [INPUT_WD-1:0]   x_q [NTAP];
    logic signed [INPUT_WD-1:0]   x_d [NTAP];
    logic                         v0_q, v0_d;
    logic [ADDR_WD-1:0]           d0_q, d0_d;
    logic                         v1_q, v1_d;
    logic [PH_WD-1:0]             ph_q;
    logic signed [INPUT_WD-1:0]   snap_q [NTAP];
    logic signed [INPUT_WD-1:0]   snap_d [NTAP];
    logic                         v2_q, v2_d;
    logic signed [PROD_WD-1:0]    prod_q [NTAP];
    logic signed [PROD_WD-1:0]    prod_d [NTAP];
    logic signed [FD_OUT_WD-1:0]  dout_q, dout_d;
    logic                         dvalid_q, dvalid_d;
    logic                         done_q, done_d;
    logic                         v_in;
    logic signed [FD_OUT_WD-1:0]  sum;

    logic [PH_WD-1:0]             lut_mem  [LUT_DEPTH];
    logic signed [COEF_WD-1:0]    coef_mem [NCOEF];

    // Configuration stores and synchronous phase read; not reset.
    always_ff @(posedge clk) begin
        if (lut_we && !start) begin
            lut_mem[lut_addr] <= lut_din;
        end
        if (coef_we && !start) begin
            coef_mem[coef_addr] <= coef_din;
        end
        ph_q <= lut_mem[d0_q];
    end

    // Line control, delay line and three-stage MAC pipeline.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        v0_d     = 1'b0;
        d0_d     = d0_q;
        v1_d     = v0_q;
        snap_d   = snap_q;
        v2_d     = v1_q;
        prod_d   = prod_q;
        dvalid_d = v2_q;
        dout_d   = dout_q;
        sum      = '0;
        v_in     = fine_din_valid && !tx_en && (state_q == ST_RUN);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (v_in) begin
                    x_d[0] = fine_din;
                    for (int k = 1; k < NTAP; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    cnt_d = cnt_q + CNT_WD'(1);
                    v0_d  = 1'b1;
                    d0_d  = cnt_q[ADDR_WD-1:0];
                    if (cnt_q == CNT_WD'(LUT_DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (v0_q) begin
            snap_d = x_q;
        end
        if (v1_q) begin
            for (int k = 0; k < NTAP; k++) begin
                prod_d[k] = PROD_WD'(coef_mem[{ph_q, 2'(k)}]) * PROD_WD'(snap_q[k]);
            end
        end
        for (int k = 0; k < NTAP; k++) begin
            sum = sum + FD_OUT_WD'(prod_q[k]);
        end
        if (v2_q) begin
            dout_d = sum;
        end

        // Dropping start flushes the line and everything in flight.
        if (!start) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            for (int k = 0; k < NTAP; k++) begin
                x_d[k] = '0;
            end
            v0_d     = 1'b0;
            v1_d     = 1'b0;
            v2_d     = 1'b0;
            dvalid_d = 1'b0;
            dout_d   = '0;
        end

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            for (int k = 0; k < NTAP; k++) begin
                x_q[k]    <= '0;
                snap_q[k] <= '0;
                prod_q[k] <= '0;
            end
            v0_q     <= 1'b0;
            d0_q     <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            v0_q     <= v0_d;
            d0_q     <= d0_d;
            v1_q     <= v1_d;
            snap_q   <= snap_d;
            v2_q     <= v2_d;
            prod_q   <= prod_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            done_q   <= done_d;
        end
    end

    assign fine_dout       = dout_q;
    assign fine_dout_valid = dvalid_q;
    assign line_done       = done_q;

endmodule

// File: tb/tb_fine_interp_ch.sv
// Directed bench for fine_interp_ch: identity, half-sample, per-depth phase,
// write gating, tx blanking, flush, async reset and end-of-line boundary.
module tb_fine_interp_ch;

    logic               clk;
    logic               rst_n;
    logic               tx_en;
    logic               start;
    logic [11:0]        lut_addr;
    logic               lut_we;
    logic [2:0]         lut_din;
    logic [4:0]         coef_addr;
    logic               coef_we;
    logic [15:0]        coef_din;
    logic [13:0]        fine_din;
    logic               fine_din_valid;
    logic signed [31:0] fine_dout;
    logic               fine_dout_valid;
    logic               line_done;

    int     checks;
    int     errors;
    longint oq [$];
    int     mark;
    int     dv [16];
    longint ev [16];

    fine_interp_ch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tx_en           (tx_en),
        .start           (start),
        .lut_addr        (lut_addr),
        .lut_we          (lut_we),
        .lut_din         (lut_din),
        .coef_addr       (coef_addr),
        .coef_we         (coef_we),
        .coef_din        (coef_din),
        .fine_din        (fine_din),
        .fine_din_valid  (fine_din_valid),
        .fine_dout       (fine_dout),
        .fine_dout_valid (fine_dout_valid),
        .line_done       (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every emitted output.
    always @(negedge clk) begin
        if (rst_n && fine_dout_valid) begin
            oq.push_back(longint'(fine_dout));
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_lut(input int a, input int v);
        lut_addr = 12'(a);
        lut_din  = 3'(v);
        lut_we   = 1'b1;
        step();
        lut_we   = 1'b0;
    endtask

    task automatic fill_lut(input int v);
        for (int a = 0; a < 4096; a++) begin
            wr_lut(a, v);
        end
    endtask

    task automatic wr_coef(input int p, input int k, input int v);
        coef_addr = 5'(p * 4 + k);
        coef_din  = 16'(v);
        coef_we   = 1'b1;
        step();
        coef_we   = 1'b0;
    endtask

    // Back-to-back samples; each output must appear exactly 3 cycles later.
    task automatic run_line(input int n, input int din_v[16], input longint ex_v[16]);
        for (int cyc = 0; cyc < n + 4; cyc++) begin
            fine_din_valid = (cyc < n);
            fine_din       = (cyc < n) ? 14'(din_v[cyc]) : 14'd0;
            step();
            if (cyc >= 3 && cyc < n + 3) begin
                chk($sformatf("valid_d%0d", cyc - 3), longint'(fine_dout_valid), 1);
                chk($sformatf("dout_d%0d", cyc - 3), longint'(fine_dout), ex_v[cyc - 3]);
            end else begin
                chk($sformatf("novalid_c%0d", cyc), longint'(fine_dout_valid), 0);
            end
        end
        fine_din_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        tx_en = 1'b0;
        start = 1'b0;
        lut_addr = '0;
        lut_we = 1'b0;
        lut_din = '0;
        coef_addr = '0;
        coef_we = 1'b0;
        coef_din = '0;
        fine_din = '0;
        fine_din_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_dout", longint'(fine_dout), 0);
        chk("rst_valid", longint'(fine_dout_valid), 0);
        chk("rst_done", longint'(line_done), 0);

        // Identity: c[0] passes x1 at unity gain.
        fill_lut(0);
        wr_coef(0, 0, 0);
        wr_coef(0, 1, 16384);
        wr_coef(0, 2, 0);
        wr_coef(0, 3, 0);
        start = 1'b1;
        step();
        dv = '{0: 1, 1: 2, 2: 3, 3: 4, 4: 5, default: 0};
        ev = '{0: 0, 1: 16384, 2: 32768, 3: 49152, 4: 65536, default: 0};
        run_line(5, dv, ev);
        chk("hold_dout", longint'(fine_dout), 65536);
        start = 1'b0;
        step();
        chk("flush_dout", longint'(fine_dout), 0);

        // Half-sample phase 4.
        fill_lut(4);
        wr_coef(4, 0, 0);
        wr_coef(4, 1, 8192);
        wr_coef(4, 2, 8192);
        wr_coef(4, 3, 0);
        start = 1'b1;
        step();
        dv = '{default: -100};
        ev = '{0: 0, 1: -819200, default: -1638400};
        run_line(6, dv, ev);
        start = 1'b0;
        step();

        // LUT write during a line must be ignored.
        wr_coef(7, 0, -16384);
        wr_coef(7, 1, 0);
        wr_coef(7, 2, 0);
        wr_coef(7, 3, 0);
        start = 1'b1;
        step();
        lut_addr = 12'd5;
        lut_din  = 3'd7;
        lut_we   = 1'b1;
        step();
        lut_we   = 1'b0;
        start    = 1'b0;
        step();
        start = 1'b1;
        step();
        dv = '{default: 10};
        ev = '{0: 0, 1: 81920, default: 163840};
        run_line(6, dv, ev);
        start = 1'b0;
        step();

        // Depth-varying phase with an impulse; LUT written just before start.
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                wr_coef(p, k, (p + 1) * 100 + k * 10 + 1);
            end
        end
        wr_lut(0, 0);
        wr_lut(1, 1);
        wr_lut(2, 2);
        wr_lut(3, 3);
        start = 1'b1;
        step();
        dv = '{0: 1000, default: 0};
        ev = '{0: 101000, 1: 211000, 2: 321000, 3: 431000, default: 0};
        run_line(4, dv, ev);
        start = 1'b0;
        step();

        // c[p] = 1000*(p+1) on x1 makes the phase (hence depth) visible.
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 4; k++) begin
                wr_coef(p, k, (k == 1) ? 1000 * (p + 1) : 0);
            end
        end

        // tx_en blanking mid-line.
        start = 1'b1;
        step();
        mark = oq.size();
        fine_din_valid = 1'b1;
        fine_din = 14'd1;
        step();
        fine_din = 14'd2;
        step();
        tx_en = 1'b1;
        fine_din = 14'd99;
        step();
        step();
        step();
        tx_en = 1'b0;
        fine_din = 14'd3;
        step();
        fine_din = 14'd4;
        step();
        fine_din_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("tx_count", longint'(oq.size() - mark), 4);
        ev = '{0: 0, 1: 2000, 2: 6000, 3: 12000, default: 0};
        for (int i = 0; i < 4; i++) begin
            if (mark + i < oq.size()) begin
                chk($sformatf("tx_out%0d", i), oq[mark + i], ev[i]);
            end
        end
        chk("tx_hold", longint'(fine_dout), 12000);

        // Flush with two samples in flight.
        mark = oq.size();
        fine_din_valid = 1'b1;
        fine_din = 14'd5;
        step();
        fine_din = 14'd6;
        step();
        fine_din_valid = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("flush_count", longint'(oq.size() - mark), 0);
        chk("flush_dout2", longint'(fine_dout), 0);
        start = 1'b1;
        step();
        dv = '{0: 5, 1: 6, default: 0};
        ev = '{0: 0, 1: 10000, default: 0};
        run_line(2, dv, ev);

        // Async reset with two samples in flight.
        mark = oq.size();
        fine_din_valid = 1'b1;
        fine_din = 14'd7;
        step();
        fine_din = 14'd8;
        step();
        fine_din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", longint'(fine_dout), 0);
        chk("arst_valid", longint'(fine_dout_valid), 0);
        start = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("arst_count", longint'(oq.size() - mark), 0);
        start = 1'b1;
        step();
        dv = '{0: 7, 1: 8, default: 0};
        ev = '{0: 0, 1: 14000, default: 0};
        run_line(2, dv, ev);
        start = 1'b0;
        step();

        // End of line: 4096 accepted, further samples blocked.
        start = 1'b1;
        step();
        mark = oq.size();
        fine_din_valid = 1'b1;
        for (int i = 0; i < 4106; i++) begin
            fine_din = 14'(i);
            step();
            if (i == 4094) chk("done_before", longint'(line_done), 0);
            if (i == 4095) chk("done_after", longint'(line_done), 1);
        end
        fine_din_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("line_count", longint'(oq.size() - mark), 4096);
        chk("done_hold", longint'(line_done), 1);
        start = 1'b0;
        step();
        chk("done_clear", longint'(line_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
